seq_elem_tester: RTL and testbench

SEQ_ELEM_TESTER -- requirements
Module: seq_elem_tester

---
 rtl/seq_elem_pkg.sv | 29 ++
 rtl/seq_elem_model.sv | 41 ++++
 rtl/seq_elem_tester.sv | 143 ++++++++++++++
 tb/tb_seq_elem_tester.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_elem_pkg.sv
// Shared types and constants for the latch/flip-flop sequential element tester.
// The 16-step {tclk,tdata} stimulus table lives here as a packed constant.
package seq_elem_pkg;

    localparam int STEP_NUM = 16;
    localparam int IDX_W    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_HOLD,
        ST_CHECK,
        ST_FIN
    } state_t;

    typedef struct packed {
        logic tclk;
        logic tdata;
    } step_t;

    // Entry i occupies bits [2i+1:2i]; entry 15 is the leftmost pair.
    localparam logic [2*STEP_NUM-1:0] STEP_TABLE =
        32'b10_00_11_01_11_10_00_10_11_10_11_10_01_00_01_00;

    function automatic step_t step_entry(input logic [IDX_W-1:0] idx);
        return step_t'(STEP_TABLE[{idx, 1'b0} +: 2]);
    endfunction

endpackage

// File: rtl/seq_elem_model.sv
// Reference models of a transparent-low latch and a rising-edge flip-flop,
// advanced once per stimulus step, with flags marking when each holds a known value.
module seq_elem_model
    import seq_elem_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clear,
    input  logic  load,
    input  step_t step,
    output logic  latch_q,
    output logic  latch_valid,
    output logic  ff_q,
    output logic  ff_valid
);

    logic prev_tclk;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            latch_q     <= 1'b0;
            latch_valid <= 1'b0;
            ff_q        <= 1'b0;
            ff_valid    <= 1'b0;
            prev_tclk   <= 1'b0;
        end else if (load) begin
            if (!step.tclk) begin
                latch_q     <= step.tdata;
                latch_valid <= 1'b1;
            end
            if (step.tclk && !prev_tclk) begin
                ff_q     <= step.tdata;
                ff_valid <= 1'b1;
            end
            prev_tclk <= step.tclk;
        end
    end

endmodule

// File: rtl/seq_elem_tester.sv
// Drives a 16-step clock/data sequence into an external latch and flip-flop and
// counts mismatches against reference models. Optional macro SEQ_ELEM_TESTER_ERRLOG_EN
// adds first_err_step/first_err_src capture of the first counted mismatch.
module seq_elem_tester
    import seq_elem_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             tclk,
    output logic             tdata,
    input  logic             dut_latch_q,
    input  logic             dut_ff_q,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt
`ifdef SEQ_ELEM_TESTER_ERRLOG_EN
    ,
    output logic [3:0]       first_err_step,
    output logic [1:0]       first_err_src
`endif
);

    localparam logic [7:0]     HOLD_LAST = 8'(HOLD_CYCLES - 3);
    localparam logic [CNT_W:0] ERR_MAX   = {1'b0, {CNT_W{1'b1}}};

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [7:0]       hold_cnt;
    logic             pass_q;
    logic             run_start;
    logic             last_step;
    step_t            cur_step;

    logic             latch_model;
    logic             latch_valid;
    logic             ff_model;
    logic             ff_valid;
    logic             latch_mis;
    logic             ff_mis;
    logic [1:0]       mis_add;
    logic [CNT_W:0]   err_sum;
    logic [CNT_W-1:0] err_nxt;

    assign run_start = (state == ST_IDLE) && start;
    assign last_step = (idx == IDX_W'(STEP_NUM - 1));
    assign cur_step  = step_entry(idx);

    seq_elem_model u_model (
        .clk         (clk),
        .rst         (rst),
        .clear       (run_start),
        .load        (state == ST_DRIVE),
        .step        (cur_step),
        .latch_q     (latch_model),
        .latch_valid (latch_valid),
        .ff_q        (ff_model),
        .ff_valid    (ff_valid)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_DRIVE;
            ST_DRIVE: state_nxt = (HOLD_CYCLES > 2) ? ST_HOLD : ST_CHECK;
            ST_HOLD:  if (hold_cnt == HOLD_LAST) state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = last_step ? ST_FIN : ST_DRIVE;
            ST_FIN:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Mismatches only count once the corresponding model holds a known value.
    assign latch_mis = (state == ST_CHECK) && latch_valid && (dut_latch_q != latch_model);
    assign ff_mis    = (state == ST_CHECK) && ff_valid && (dut_ff_q != ff_model);

    always_comb begin
        mis_add = {1'b0, latch_mis} + {1'b0, ff_mis};
        err_sum = {1'b0, err_cnt} + (CNT_W + 1)'(mis_add);
        err_nxt = (err_sum > ERR_MAX) ? ERR_MAX[CNT_W-1:0] : err_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            hold_cnt <= '0;
            tclk     <= 1'b0;
            tdata    <= 1'b0;
            err_cnt  <= '0;
            pass_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (run_start) begin
                idx     <= '0;
                err_cnt <= '0;
                pass_q  <= 1'b0;
            end
            if (state == ST_DRIVE) begin
                tclk     <= cur_step.tclk;
                tdata    <= cur_step.tdata;
                hold_cnt <= '0;
            end
            if (state == ST_HOLD) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
            if (state == ST_CHECK) begin
                err_cnt <= err_nxt;
                idx     <= idx + IDX_W'(1);
                if (last_step) begin
                    pass_q <= (err_nxt == '0);
                end
            end
        end
    end

`ifdef SEQ_ELEM_TESTER_ERRLOG_EN
    logic logged;

    always_ff @(posedge clk) begin
        if (rst || run_start) begin
            logged         <= 1'b0;
            first_err_step <= '0;
            first_err_src  <= '0;
        end else if (!logged && (latch_mis || ff_mis)) begin
            logged         <= 1'b1;
            first_err_step <= idx;
            first_err_src  <= {ff_mis, latch_mis};
        end
    end
`endif

    assign busy = (state == ST_DRIVE) || (state == ST_HOLD) || (state == ST_CHECK);
    assign done = (state == ST_FIN);
    assign pass = pass_q;

endmodule

// File: tb/tb_seq_elem_tester.sv
// Directed bench for seq_elem_tester: behavioural latch/ff under test with fault modes,
// mid-run reset, start-while-busy, and a CNT_W=2 instance exercising saturation.
module tb_seq_elem_tester;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       tclk;
    logic       tdata;
    logic       latch_q;
    logic       ff_q;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_cnt;

    logic       s_start;
    logic       s_tclk;
    logic       s_tdata;
    logic       s_busy;
    logic       s_done;
    logic       s_pass;
    logic [1:0] s_err_cnt;

`ifdef SEQ_ELEM_TESTER_ERRLOG_EN
    logic [3:0] first_err_step;
    logic [1:0] first_err_src;
    logic [3:0] s_first_err_step;
    logic [1:0] s_first_err_src;
`endif

    logic beh_latch = 1'b0;
    logic beh_ff    = 1'b0;
    logic s_latch   = 1'b0;
    logic s_ff      = 1'b0;
    int   mode      = 0;   // 0 good, 1 ff stuck 0, 2 latch always transparent
    int   checks    = 0;
    int   errors    = 0;

    always #5 clk = ~clk;

    always @(tclk or tdata) if (!tclk) beh_latch = tdata;
    always @(posedge tclk) beh_ff <= tdata;
    always @(s_tclk or s_tdata) if (!s_tclk) s_latch = s_tdata;
    always @(posedge s_tclk) s_ff <= s_tdata;

    always_comb begin
        latch_q = beh_latch;
        ff_q    = beh_ff;
        if (mode == 1) ff_q = 1'b0;
        if (mode == 2) latch_q = tdata;
    end

    seq_elem_tester dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .tclk        (tclk),
        .tdata       (tdata),
        .dut_latch_q (latch_q),
        .dut_ff_q    (ff_q),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .err_cnt     (err_cnt)
`ifdef SEQ_ELEM_TESTER_ERRLOG_EN
        ,
        .first_err_step (first_err_step),
        .first_err_src  (first_err_src)
`endif
    );

    seq_elem_tester #(.HOLD_CYCLES(4), .CNT_W(2)) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .start       (s_start),
        .tclk        (s_tclk),
        .tdata       (s_tdata),
        .dut_latch_q (~s_latch),
        .dut_ff_q    (~s_ff),
        .busy        (s_busy),
        .done        (s_done),
        .pass        (s_pass),
        .err_cnt     (s_err_cnt)
`ifdef SEQ_ELEM_TESTER_ERRLOG_EN
        ,
        .first_err_step (s_first_err_step),
        .first_err_src  (s_first_err_src)
`endif
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Returns the run length in cycles, counting both the start cycle and the done cycle.
    task automatic run(input bit pulse_mid, output int len);
        int n;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
            start = (pulse_mid && n == 20);
        end
        start = 1'b0;
        if (!done) check("run_timeout", done, 1'b1);
        len = n + 1;
    endtask

    initial begin
        int len;
        int n;
        rst     = 1'b1;
        start   = 1'b0;
        s_start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_err", err_cnt, 8'd0);
        check("rst_tclk", tclk, 1'b0);
        check("rst_tdata", tdata, 1'b0);

        // Reset wins over a coincident start.
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_prio_busy", busy, 1'b0);

        // Healthy elements.
        mode = 0;
        run(1'b0, len);
        check("good_len", len, 65);
        check("good_err", err_cnt, 8'd0);
        check("good_pass", pass, 1'b1);
        check("good_last_tclk", tclk, 1'b1);
        check("good_last_tdata", tdata, 1'b0);
        @(negedge clk);
        check("good_done_pulse", done, 1'b0);
        check("good_idle_busy", busy, 1'b0);
        check("good_pass_held", pass, 1'b1);

        // Flip-flop output stuck at 0: ff model is 1 at steps 13 and 14.
        mode = 1;
        run(1'b0, len);
        check("ff0_len", len, 65);
        check("ff0_err", err_cnt, 8'd2);
        check("ff0_pass", pass, 1'b0);

        // Latch always transparent, with a start pulse while busy.
        mode = 2;
        run(1'b1, len);
        check("lt_len", len, 65);
        check("lt_err", err_cnt, 8'd4);
        check("lt_pass", pass, 1'b0);
`ifdef SEQ_ELEM_TESTER_ERRLOG_EN
        check("lt_first_step", first_err_step, 4'd4);
        check("lt_first_src", first_err_src, 2'b01);
`endif

        // Reset during step 7; steps 4 and 6 have already been counted.
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (28) @(negedge clk);
        check("mid_err_before", err_cnt, 8'd2);
        check("mid_tclk_before", tclk, 1'b1);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("mid_busy", busy, 1'b0);
        check("mid_tclk", tclk, 1'b0);
        check("mid_err", err_cnt, 8'd0);
        check("mid_done", done, 1'b0);
        check("mid_pass", pass, 1'b0);

        mode = 0;
        run(1'b0, len);
        check("post_rst_len", len, 65);
        check("post_rst_err", err_cnt, 8'd0);
        check("post_rst_pass", pass, 1'b1);

        // Narrow counter with both outputs inverted.
        @(negedge clk) s_start = 1'b1;
        @(negedge clk) s_start = 1'b0;
        n = 0;
        while (!s_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("sat_len", n + 1, 65);
        check("sat_err", s_err_cnt, 2'd3);
        check("sat_pass", s_pass, 1'b0);
`ifdef SEQ_ELEM_TESTER_ERRLOG_EN
        check("sat_first_step", s_first_err_step, 4'd0);
        check("sat_first_src", s_first_err_src, 2'b01);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
